// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline stage with a main register, a one-entry skid
// register and a synchronous flush. in_ready/out_valid are decoded from the
// state register only, so no ready path crosses the stage combinationally.
module pipe_skid_reg #(
    parameter int unsigned            WIDTH        = 32,
    parameter logic [WIDTH-1:0]       RESET_VALUE  = '0,
    parameter logic [WIDTH-1:0]       BUBBLE_VALUE = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next data contents; flush overrides every handshake
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE_VALUE;
            w_skid_nxt  = BUBBLE_VALUE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = ST_FULL;
                    end else if (w_out_fire) begin
                        w_main_nxt  = BUBBLE_VALUE;
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE_VALUE;
                        w_state_nxt = ST_BUSY;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Data registers; they only change on the transitions chosen above
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_main <= RESET_VALUE;
            r_skid <= RESET_VALUE;
        end else begin
            r_main <= w_main_nxt;
            r_skid <= w_skid_nxt;
        end
    end

    // Outputs decoded from the state register only
    always_comb begin
        in_ready  = (r_state != ST_FULL);
        out_valid = (r_state != ST_EMPTY);
        out_data  = r_main;
        case (r_state)
            ST_BUSY: occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline register: the successor to the fixed 32-bit stall-gated stage register. Replaces the global stall wire with a per-stage valid/ready handshake, a 2-entry skid buffer (main + skid) and a synchronous flush that inserts a bubble. Sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) so backpressure is local and carries no combinational ready path across stages.

Parameters:
WIDTH, 32, data bits per entry
RESET_VALUE, 0, value of main/skid data registers after asynchronous reset
BUBBLE_VALUE, 0, value loaded into emptied/flushed entries (e.g. NOP encoding)

Ports:
clk  input  1  rising-edge clock
clrn  input  1  asynchronous active-low reset
flush  input  1  synchronous flush, discards all held and incoming data
in_valid  input  1  upstream has data on in_data
in_ready  output  1  stage can accept; registered, a function of state only
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  main register contents
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Reset (clrn=0, asynchronous, any time incl. mid-transfer): state EMPTY; main=skid=RESET_VALUE; out_valid=0; in_ready=1; occupancy=0.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; all updates on posedge clk.
- States: EMPTY (occ 0), BUSY (occ 1, main valid), FULL (occ 2, main+skid valid).
- out_valid = (state != EMPTY); in_ready = (state != FULL); both decoded from the state register only; no in_valid->in_ready or out_ready->in_ready combinational path.
- EMPTY: in_fire -> main<=in_data, BUSY. Otherwise hold.
- BUSY: in_fire & out_fire -> main<=in_data, stay BUSY (full throughput). in_fire & !out_ready -> skid<=in_data, FULL. !in_fire & out_fire -> main<=BUBBLE_VALUE, EMPTY. Neither -> hold.
- FULL: in_ready=0, so in_valid is ignored. out_fire -> main<=skid, skid<=BUBBLE_VALUE, BUSY. Otherwise hold.
- Latency: data accepted at edge N appears on out_data after edge N (1 cycle). Sustained throughput is 1 entry/cycle when out_ready stays high.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush or reset.
- Flush (synchronous, highest priority over any handshake in the same cycle): next state EMPTY; main=skid=BUBBLE_VALUE; the in_data presented that cycle is discarded even if in_fire; an out_fire that cycle still counts as consumed downstream.
- When out_valid=0, out_data shows BUBBLE_VALUE, or RESET_VALUE if no entry has been loaded since reset. Downstream must qualify out_data with out_valid.
- Data registers load only on the transitions listed above. With no handshake and no flush, all registers hold (legacy stall behaviour = out_ready held low).
- Any WIDTH>=1 is legal. No arithmetic on data.

Test Plan:
- Reset: drive clrn=0 mid-stream with state FULL -> immediately out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VALUE (0).
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each; in_ready stays 1; occupancy=1 throughout.
- Backpressure: BUSY holding 0xA, out_ready=0, push 0xB -> FULL, in_ready=0, occupancy=2; in_valid with 0xC ignored. Raise out_ready for 2 cycles -> outputs 0xA then 0xB; then EMPTY, out_data=BUBBLE_VALUE.
- Flush priority: FULL with 0x5,0x6, assert flush with in_valid=1, in_data=0x7, out_ready=1 -> next cycle EMPTY, out_valid=0, out_data=BUBBLE_VALUE; 0x7 never emitted.
- Parameter override: WIDTH=8, BUBBLE_VALUE=8'h13, RESET_VALUE=8'hFF -> after reset out_data=0xFF; after one transfer drains, out_data=0x13.
- Random valid/ready (10k cycles) against a scoreboard -> zero loss, duplication or reorder; in_ready=0 only while occupancy=2.
